// File: rtl/mipi_csi_rx_raw_depacker_gen.sv
// mipi_csi_rx_raw_depacker_gen: RAW8/10/12/14 byte-to-pixel gearbox with end-of-line flush and error pulses.
// Define DEPACKER_PIXEL_COUNT_EN to add the per-line pixel_count_o output.
module mipi_csi_rx_raw_depacker_gen #(
    parameter int LANES         = 4,
    parameter int PIXEL_WIDTH   = 16,
    parameter int PIXEL_PER_CLK = 4,
    parameter int BUF_BYTES     = 2*LANES + 2*PIXEL_PER_CLK
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 data_valid_i,
    input  logic [8*LANES-1:0]                   data_i,
    input  logic [2:0]                           packet_type_i,
    output logic                                 output_valid_o,
    output logic [PIXEL_WIDTH*PIXEL_PER_CLK-1:0] output_o,
    output logic                                 line_end_o,
    output logic                                 err_partial_o,
    output logic                                 err_type_o,
`ifdef DEPACKER_PIXEL_COUNT_EN
    output logic [15:0]                          pixel_count_o,
`endif
    output logic                                 err_overrun_o
);
    localparam int GROUPS = PIXEL_PER_CLK / 4;
    localparam int FW     = $clog2(BUF_BYTES + LANES + 1);
    localparam int BW     = 8 * BUF_BYTES;

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP, FLUSH} state_t;

    if (PIXEL_PER_CLK % 4 != 0 || PIXEL_PER_CLK < LANES ||
        !(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8) ||
        PIXEL_WIDTH < 14 || PIXEL_WIDTH > 16) begin : g_param_check
        $error("mipi_csi_rx_raw_depacker_gen: illegal LANES/PIXEL_PER_CLK/PIXEL_WIDTH");
    end

    state_t                               state_q, state_d;
    logic [2:0]                           type_q;
    logic [FW-1:0]                        fill_q, fill_d, need, fill_shift, fill_sum;
    logic [BW-1:0]                        buf_q, buf_d;
    logic                                 supported, start, emit, append, overflow, flush_done;
    logic [PIXEL_WIDTH*PIXEL_PER_CLK-1:0] pix;
    logic [15:0]                          p8, p10, p12, p14, p;
    logic [23:0]                          l14;

    assign supported = packet_type_i inside {3'd0, 3'd3, 3'd4, 3'd5};
    assign need = type_q == 3'd3 ? FW'(PIXEL_PER_CLK * 5 / 4) :
                  type_q == 3'd4 ? FW'(PIXEL_PER_CLK * 6 / 4) :
                  type_q == 3'd5 ? FW'(PIXEL_PER_CLK * 7 / 4) : FW'(PIXEL_PER_CLK);

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q == IDLE   ? (data_valid_i ? (supported ? ACTIVE : DROP) : IDLE) :
                  state_q == ACTIVE ? (data_valid_i ? ACTIVE : FLUSH) :
                  state_q == DROP   ? (data_valid_i ? DROP : IDLE) :
                  (emit ? FLUSH : IDLE);
    end

    always_comb begin
        start      = state_q == IDLE && data_valid_i;
        emit       = (state_q == ACTIVE || state_q == FLUSH) && fill_q >= need;
        append     = data_valid_i && (state_q == ACTIVE || (start && supported));
        flush_done = state_q == FLUSH && !emit;
        fill_shift = emit ? fill_q - need : fill_q;
        fill_sum   = fill_shift + (append ? FW'(LANES) : FW'(0));
        overflow   = fill_sum > FW'(BUF_BYTES);
        fill_d     = flush_done ? '0 : overflow ? FW'(BUF_BYTES) : fill_sum;
    end

    // Bytes above fill are kept zero so new bytes can be OR-ed in after the shift.
    assign buf_d = flush_done ? '0 :
                   (emit ? buf_q >> (8 * need) : buf_q) |
                   (append ? BW'(data_i) << (8 * fill_shift) : '0);

    always_comb begin
        pix = '0;
        p8  = '0;
        p10 = '0;
        p12 = '0;
        p14 = '0;
        p   = '0;
        l14 = '0;
        for (int g = 0; g < GROUPS; g++) begin
            for (int i = 0; i < 4; i++) begin
                p8  = {buf_q[8*(4*g+i) +: 8], 8'h00};
                p10 = {buf_q[8*(5*g+i) +: 8], 2'(buf_q[8*(5*g+4) +: 8] >> (2*i)), 6'h00};
                p12 = {buf_q[8*(6*g+(i < 2 ? i : i+1)) +: 8],
                       4'(buf_q[8*(6*g+(i < 2 ? 2 : 5)) +: 8] >> (4*(i%2))), 4'h0};
                l14 = buf_q[8*(7*g+4) +: 24];
                p14 = {buf_q[8*(7*g+i) +: 8], l14[6*i +: 6], 2'h0};
                p   = type_q == 3'd3 ? p10 : type_q == 3'd4 ? p12 : type_q == 3'd5 ? p14 : p8;
                pix[PIXEL_WIDTH*(4*g+i) +: PIXEL_WIDTH] = p[15 -: PIXEL_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            type_q         <= '0;
            fill_q         <= '0;
            buf_q          <= '0;
            output_valid_o <= 1'b0;
            output_o       <= '0;
            line_end_o     <= 1'b0;
            err_partial_o  <= 1'b0;
            err_type_o     <= 1'b0;
            err_overrun_o  <= 1'b0;
        end else begin
            if (start) type_q <= packet_type_i;
            fill_q         <= fill_d;
            buf_q          <= buf_d;
            output_valid_o <= emit;
            if (emit) output_o <= pix;
            line_end_o     <= flush_done;
            err_partial_o  <= flush_done && fill_q != '0;
            err_type_o     <= start && !supported;
            err_overrun_o  <= (state_q == FLUSH && data_valid_i) || overflow;
        end
    end

`ifdef DEPACKER_PIXEL_COUNT_EN
    logic [16:0] pc_sum;
    assign pc_sum = {1'b0, pixel_count_o} + 17'(PIXEL_PER_CLK);

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) pixel_count_o <= '0;
        else if (start && supported) pixel_count_o <= '0;
        else if (emit) pixel_count_o <= pc_sum[16] ? 16'hFFFF : pc_sum[15:0];
`endif
endmodule

// File: tb/tb_mipi_csi_rx_raw_depacker_gen.sv
// tb_mipi_csi_rx_raw_depacker_gen: table-driven line checks on a 4-lane instance plus
// hand sequences for reset, mid-line reset and an 8-lane RAW8 overrun case.
module tb_mipi_csi_rx_raw_depacker_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         va, vb;
    logic [31:0]  da;
    logic [63:0]  db;
    logic [2:0]   ta, tb_t;
    logic         ova, ovb, lea, leb, epa, epb, eta, etb, eoa, eob;
    logic [63:0]  oa;
    logic [127:0] ob;
`ifdef DEPACKER_PIXEL_COUNT_EN
    logic [15:0]  pca, pcb;
`endif

    typedef struct {
        logic [2:0] t;
        int cycles;
        int seed;
        int beats;
        int le;
        int partial;
        int terr;
        int lat;
    } vec_t;

    vec_t         tbl[8];
    int           n_chk = 0, n_err = 0, cyc = 0;
    logic [63:0]  beats_a[64];
    int           stamp_a[64];
    int           nba = 0;
    logic [127:0] beats_b[16];
    int           stamp_b[16];
    int           nbb = 0;
    int           le_a = 0, ep_a = 0, et_a = 0, eo_a = 0, le_b = 0, ep_b = 0, eo_b = 0;

    mipi_csi_rx_raw_depacker_gen dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(va), .data_i(da), .packet_type_i(ta),
        .output_valid_o(ova), .output_o(oa), .line_end_o(lea), .err_partial_o(epa),
        .err_type_o(eta),
`ifdef DEPACKER_PIXEL_COUNT_EN
        .pixel_count_o(pca),
`endif
        .err_overrun_o(eoa)
    );

    mipi_csi_rx_raw_depacker_gen #(.LANES(8), .PIXEL_PER_CLK(8)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .data_valid_i(vb), .data_i(db), .packet_type_i(tb_t),
        .output_valid_o(ovb), .output_o(ob), .line_end_o(leb), .err_partial_o(epb),
        .err_type_o(etb),
`ifdef DEPACKER_PIXEL_COUNT_EN
        .pixel_count_o(pcb),
`endif
        .err_overrun_o(eob)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ova && nba < 64) begin
            beats_a[nba] = oa;
            stamp_a[nba] = cyc;
            nba++;
        end
        if (ovb && nbb < 16) begin
            beats_b[nbb] = ob;
            stamp_b[nbb] = cyc;
            nbb++;
        end
        le_a += int'(lea); ep_a += int'(epa); et_a += int'(eta); eo_a += int'(eoa);
        le_b += int'(leb); ep_b += int'(epb); eo_b += int'(eob);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] t);
        return t == 3'd3 ? 5 : t == 3'd4 ? 6 : t == 3'd5 ? 7 : 4;
    endfunction

    // Reference 4-pixel group built with integer arithmetic from the byte formulas.
    function automatic logic [63:0] model(input logic [2:0] t, input int base);
        int b[7];
        int p;
        int l;
        logic [63:0] r = '0;
        for (int j = 0; j < 7; j++) b[j] = (base + j) & 255;
        l = b[4] | (b[5] << 8) | (b[6] << 16);
        for (int i = 0; i < 4; i++) begin
            case (t)
                3'd3: p = (b[i] << 8) | (((b[4] >> (2*i)) & 3) << 6);
                3'd4: p = (b[i < 2 ? i : i + 1] << 8) | ((((i < 2 ? b[2] : b[5]) >> (4*(i%2))) & 15) << 4);
                3'd5: p = (b[i] << 8) | (((l >> (6*i)) & 63) << 2);
                default: p = b[i] << 8;
            endcase
            r[16*i +: 16] = 16'(p);
        end
        return r;
    endfunction

    task automatic run_line(input vec_t v, output int first_idx);
        int s_nb, s_le, s_ep, s_et, s_eo, start;
        s_nb = nba; s_le = le_a; s_ep = ep_a; s_et = et_a; s_eo = eo_a;
        start = cyc;
        first_idx = nba;
        for (int c = 0; c < v.cycles; c++) begin
            for (int k = 0; k < 4; k++) da[8*k +: 8] = 8'(v.seed + 4*c + k);
            ta = v.t;
            va = 1'b1;
            @(posedge clk); #1;
        end
        va = 1'b0;
        da = '0;
        repeat (12) @(posedge clk);
        #1;
        chki($sformatf("t%0d beats", v.t), nba - s_nb, v.beats);
        chki($sformatf("t%0d line_end", v.t), le_a - s_le, v.le);
        chki($sformatf("t%0d err_partial", v.t), ep_a - s_ep, v.partial);
        chki($sformatf("t%0d err_type", v.t), et_a - s_et, v.terr);
        chki($sformatf("t%0d err_overrun", v.t), eo_a - s_eo, 0);
        for (int k = 0; k < v.beats && s_nb + k < nba; k++)
            chk($sformatf("t%0d beat%0d", v.t, k), 128'(beats_a[s_nb + k]),
                128'(model(v.t, v.seed + k * nbytes(v.t))));
        if (v.beats > 0 && nba > s_nb) chki($sformatf("t%0d latency", v.t), stamp_a[s_nb] - start, v.lat);
`ifdef DEPACKER_PIXEL_COUNT_EN
        if (v.le != 0) chki($sformatf("t%0d pixel_count", v.t), int'(pca), 4 * v.beats);
`endif
    endtask

    initial begin
        int idx, s_b, s_le, s_ep, s_eo, s_sum, start;
        logic [127:0] e;
        tbl[0] = '{3'd3, 10, 'h00, 8, 1, 0, 0, 3};
        tbl[1] = '{3'd4,  3, 'h40, 2, 1, 0, 0, 3};
        tbl[2] = '{3'd5,  2, 'h80, 1, 1, 1, 0, 3};
        tbl[3] = '{3'd1,  5, 'h10, 0, 0, 0, 1, 0};
        tbl[4] = '{3'd0,  3, 'hF0, 3, 1, 0, 0, 2};
        tbl[5] = '{3'd4,  2, 'h33, 1, 1, 1, 0, 3};
        tbl[6] = '{3'd3,  1, 'h77, 0, 1, 1, 0, 0};
        tbl[7] = '{3'd5,  7, 'h5A, 4, 1, 0, 0, 3};
        rst_n = 1'b0; va = 1'b0; vb = 1'b0; da = '0; db = '0; ta = '0; tb_t = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a", 128'({ova, oa, lea, epa, eta, eoa}), '0);
        chk("reset_b_data", ob, '0);
        chk("reset_b_flags", 128'({ovb, leb, epb, etb, eob}), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RAW10 line cut by an asynchronous reset after three cycles
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) da[8*k +: 8] = 8'(8'h20 + 4*c + k);
            ta = 3'd3;
            va = 1'b1;
            @(posedge clk); #1;
        end
        chk("pre_reset_valid", 128'(ova), 128'(1));
        s_sum = le_a + ep_a + eo_a + et_a;
        rst_n = 1'b0;
        #1;
        chk("async_reset_a", 128'({ova, oa, lea, epa, eta, eoa}), '0);
        va = 1'b0;
        da = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chki("reset_no_pulse", le_a + ep_a + eo_a + et_a, s_sum);

        for (int n = 0; n < 8; n++) begin
            run_line(tbl[n], idx);
            if (n == 0 && idx < nba) chk("raw10_first_beat", 128'(beats_a[idx]), 128'(64'h0300_0200_0140_0000));
        end

        // 8-lane RAW8 line, then data_valid_i re-asserted during FLUSH
        s_b = nbb; s_le = le_b; s_ep = ep_b; s_eo = eo_b;
        start = cyc;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 8; k++) db[8*k +: 8] = 8'(8'hA0 + 8*c + k);
            tb_t = 3'd0;
            vb = 1'b1;
            @(posedge clk); #1;
        end
        vb = 1'b0;
        @(posedge clk); #1;
        vb = 1'b1;
        @(posedge clk); #1;
        vb = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chki("b_beats", nbb - s_b, 4);
        chki("b_line_end", le_b - s_le, 1);
        chki("b_err_partial", ep_b - s_ep, 0);
        chki("b_err_overrun", eo_b - s_eo, 1);
        for (int k = 0; k < 4 && s_b + k < nbb; k++) begin
            e = '0;
            for (int i = 0; i < 8; i++) e[16*i +: 16] = {8'(8'hA0 + 8*k + i), 8'h00};
            chk($sformatf("b_beat%0d", k), beats_b[s_b + k], e);
        end
        if (nbb - s_b == 4) begin
            chki("b_consecutive", stamp_b[s_b + 3] - stamp_b[s_b], 3);
            chki("b_latency", stamp_b[s_b] - start, 2);
        end
`ifdef DEPACKER_PIXEL_COUNT_EN
        chki("b_pixel_count", int'(pcb), 32);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
